// File: rtl/cache_pkg.sv
// cache_pkg
//   Shared sizing constants and FSM state encodings for the read-cache /
//   write-through RAM front end (cache_no_mode_top and its RAM model).
//   No ports; imported by the interface, the RAM model and the top.
package cache_pkg;

  localparam int ADDR_W      = 32;                   // byte address width
  localparam int DATA_W      = 32;                   // word width
  localparam int RAM_DEPTH   = 256;                  // RAM words
  localparam int RAM_AW      = $clog2(RAM_DEPTH);    // RAM word-index width
  localparam int RAM_LATENCY = 4;                    // cycles per RAM access
  localparam int CACHE_LINES = 16;                   // one word per line
  localparam int IDX_W       = $clog2(CACHE_LINES);  // line index width
  localparam int WORD_W      = ADDR_W - 2;           // word address width
  localparam int TAG_W       = WORD_W - IDX_W;       // tag = address[31:6]
  localparam int LAT_W       = $clog2(RAM_LATENCY + 1);

  typedef enum logic {
    WR_IDLE  = 1'b0,
    WR_WRITE = 1'b1
  } wr_state_e;

  typedef enum logic [1:0] {
    RD_IDLE      = 2'd0,
    RD_LOOKUP    = 2'd1,
    RD_MISS_WAIT = 2'd2,
    RD_FILL      = 2'd3
  } rd_state_e;

endpackage

// File: rtl/cache_no_mode_if.sv
// cache_no_mode_if
//   Request/response bundle between a requesting master and the cache.
//   master : drives wr_address/wr_data/wr_mode/rd_address, sees busy + rd_data
//   slave  : the cache; drives wr_response, rd_response, rd_data
interface cache_no_mode_if;
  import cache_pkg::*;

  logic [ADDR_W-1:0] wr_address;
  logic [DATA_W-1:0] wr_data;
  logic              wr_mode;
  logic              wr_response;
  logic [ADDR_W-1:0] rd_address;
  logic              rd_response;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output wr_address, wr_data, wr_mode, rd_address,
    input  wr_response, rd_response, rd_data
  );

  modport slave (
    input  wr_address, wr_data, wr_mode, rd_address,
    output wr_response, rd_response, rd_data
  );

endinterface

// File: rtl/ram_model.sv
// ram_model
//   Single-port word RAM with a fixed access latency. An access started at
//   edge N completes at edge N+RAM_LATENCY: a write lands in the array on
//   that edge, and for a read rdata shows the addressed word while done=1.
//   Reset aborts an in-flight access (a pending write is dropped); the
//   array contents themselves are never reset.
//   Ports: clk, rst_n, addr (word index), wdata, we, start,
//          busy (access in flight), done (final cycle of access), rdata.
module ram_model
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RAM_AW-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              we,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [RAM_DEPTH];
  logic [RAM_AW-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic              we_r;
  logic              busy_r;
  logic [LAT_W-1:0]  cnt_r;

  assign busy  = busy_r;
  assign done  = busy_r && (cnt_r == LAT_W'(0));
  assign rdata = mem_r[addr_r];

  // Access tracking: latch the request and count down the latency.
  // A new start is taken on the completing edge, allowing back-to-back use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r  <= 1'b0;
      cnt_r   <= LAT_W'(0);
      addr_r  <= {RAM_AW{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
      we_r    <= 1'b0;
    end else if (start && (!busy_r || done)) begin
      busy_r  <= 1'b1;
      cnt_r   <= LAT_W'(RAM_LATENCY - 1);
      addr_r  <= addr;
      wdata_r <= wdata;
      we_r    <= we;
    end else if (done) begin
      busy_r  <= 1'b0;
    end else if (busy_r) begin
      cnt_r   <= cnt_r - LAT_W'(1);
    end
  end

  // Word array: written only on the completing edge of a write access.
  always_ff @(posedge clk) begin
    if (done && we_r) begin
      mem_r[addr_r] <= wdata_r;
    end
  end

endmodule

// File: rtl/cache_no_mode_top.sv
// cache_no_mode_top
//   Direct-mapped, one-word-per-line read cache in front of ram_model, plus a
//   write-through / no-allocate write port that also refreshes a matching line.
//   Requests are change-detected: a port takes a new request when its FSM is
//   idle and the request differs from the last one it accepted (the first
//   request after reset is always taken). Writes own the RAM with priority; a
//   read taken while a write is busy waits in LOOKUP until the write is done.
//   Ports: clk, rst_n (async, active low), bus (cache_no_mode_if.slave).
module cache_no_mode_top
  import cache_pkg::*;
(
  input logic            clk,
  input logic            rst_n,
  cache_no_mode_if.slave bus
);

  // Request side
  logic [WORD_W-1:0] wr_word_s, rd_word_s;
  logic [WORD_W-1:0] wr_word_r, rd_word_r;
  logic [DATA_W-1:0] wr_data_r;
  logic              have_wr_r, have_rd_r;
  logic              wr_accept_s, rd_accept_s;
  logic              unused_addr_bits_s;

  // FSMs
  wr_state_e         wr_state_r, wr_state_s;
  rd_state_e         rd_state_r, rd_state_s;
  logic [LAT_W-1:0]  miss_cnt_r, miss_cnt_s;
  logic              wr_done_s, rd_hit_done_s, rd_fill_done_s, rd_miss_start_s;

  // Cache arrays
  logic [CACHE_LINES-1:0] valid_r;
  logic [TAG_W-1:0]       tag_r  [CACHE_LINES];
  logic [DATA_W-1:0]      line_r [CACHE_LINES];
  logic [IDX_W-1:0]       rd_idx_s, wr_idx_s;
  logic [TAG_W-1:0]       rd_tag_s, wr_tag_s;
  logic                   rd_hit_s, wr_hit_s;

  // RAM port
  logic [RAM_AW-1:0] ram_addr_s;
  logic              ram_we_s, ram_start_s, ram_busy_s, ram_done_s;
  logic [DATA_W-1:0] ram_rdata_s;

  // Outputs
  logic              wr_response_r, rd_response_r;
  logic [DATA_W-1:0] rd_data_r;

  // Byte-offset bits carry no meaning for word accesses.
  assign wr_word_s          = bus.wr_address[ADDR_W-1:2];
  assign rd_word_s          = bus.rd_address[ADDR_W-1:2];
  assign unused_addr_bits_s = ^{bus.wr_address[1:0], bus.rd_address[1:0]};

  // A write needs the RAM free (or freeing this edge); a read miss in flight
  // therefore holds off a new write until its fill edge.
  assign wr_accept_s = bus.wr_mode && (wr_state_r == WR_IDLE) &&
                       (!ram_busy_s || ram_done_s) &&
                       (!have_wr_r || ({wr_word_s, bus.wr_data} != {wr_word_r, wr_data_r}));
  assign rd_accept_s = (rd_state_r == RD_IDLE) &&
                       (!have_rd_r || (rd_word_s != rd_word_r));

  assign rd_idx_s = rd_word_r[IDX_W-1:0];
  assign rd_tag_s = rd_word_r[WORD_W-1:IDX_W];
  assign wr_idx_s = wr_word_r[IDX_W-1:0];
  assign wr_tag_s = wr_word_r[WORD_W-1:IDX_W];
  assign rd_hit_s = valid_r[rd_idx_s] && (tag_r[rd_idx_s] == rd_tag_s);
  assign wr_hit_s = valid_r[wr_idx_s] && (tag_r[wr_idx_s] == wr_tag_s);

  // Write FSM next state: hold in WRITE until the RAM completes the store.
  always_comb begin
    wr_state_s = wr_state_r;
    wr_done_s  = 1'b0;
    case (wr_state_r)
      WR_IDLE: begin
        if (wr_accept_s) wr_state_s = WR_WRITE;
        else             wr_state_s = WR_IDLE;
      end
      WR_WRITE: begin
        if (ram_done_s) begin
          wr_state_s = WR_IDLE;
          wr_done_s  = 1'b1;
        end else begin
          wr_state_s = WR_WRITE;
        end
      end
      default: wr_state_s = WR_IDLE;
    endcase
  end

  // Read FSM next state. LOOKUP does nothing while a write owns the RAM, and
  // a miss never starts on an edge where a new write is being accepted.
  always_comb begin
    rd_state_s      = rd_state_r;
    miss_cnt_s      = miss_cnt_r;
    rd_hit_done_s   = 1'b0;
    rd_fill_done_s  = 1'b0;
    rd_miss_start_s = 1'b0;
    case (rd_state_r)
      RD_IDLE: begin
        if (rd_accept_s) rd_state_s = RD_LOOKUP;
        else             rd_state_s = RD_IDLE;
      end
      RD_LOOKUP: begin
        if (wr_state_r != WR_IDLE) begin
          rd_state_s = RD_LOOKUP;
        end else if (rd_hit_s) begin
          rd_state_s    = RD_IDLE;
          rd_hit_done_s = 1'b1;
        end else if (!wr_accept_s) begin
          rd_state_s      = RD_MISS_WAIT;
          rd_miss_start_s = 1'b1;
          miss_cnt_s      = LAT_W'(RAM_LATENCY - 2);
        end else begin
          rd_state_s = RD_LOOKUP;
        end
      end
      RD_MISS_WAIT: begin
        if (miss_cnt_r == LAT_W'(0)) rd_state_s = RD_FILL;
        else                         miss_cnt_s = miss_cnt_r - LAT_W'(1);
      end
      RD_FILL: begin
        // FILL lines up with the RAM's completing edge.
        if (ram_done_s) begin
          rd_state_s     = RD_IDLE;
          rd_fill_done_s = 1'b1;
        end else begin
          rd_state_s = RD_FILL;
        end
      end
      default: rd_state_s = RD_IDLE;
    endcase
  end

  // RAM port mux: write and read-miss starts are mutually exclusive.
  always_comb begin
    ram_start_s = wr_accept_s || rd_miss_start_s;
    ram_we_s    = 1'b0;
    if (wr_accept_s) begin
      ram_addr_s = wr_word_s[RAM_AW-1:0];
      ram_we_s   = 1'b1;
    end else begin
      ram_addr_s = rd_word_r[RAM_AW-1:0];
    end
  end

  ram_model u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (ram_addr_s),
    .wdata (bus.wr_data),
    .we    (ram_we_s),
    .start (ram_start_s),
    .busy  (ram_busy_s),
    .done  (ram_done_s),
    .rdata (ram_rdata_s)
  );

  // FSM state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_r <= WR_IDLE;
      rd_state_r <= RD_IDLE;
      miss_cnt_r <= LAT_W'(0);
    end else begin
      wr_state_r <= wr_state_s;
      rd_state_r <= rd_state_s;
      miss_cnt_r <= miss_cnt_s;
    end
  end

  // Last accepted requests: both the change-detect reference and the
  // operands of the operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_word_r <= {WORD_W{1'b0}};
      wr_data_r <= {DATA_W{1'b0}};
      rd_word_r <= {WORD_W{1'b0}};
      have_wr_r <= 1'b0;
      have_rd_r <= 1'b0;
    end else begin
      if (wr_accept_s) begin
        wr_word_r <= wr_word_s;
        wr_data_r <= bus.wr_data;
        have_wr_r <= 1'b1;
      end
      if (rd_accept_s) begin
        rd_word_r <= rd_word_s;
        have_rd_r <= 1'b1;
      end
    end
  end

  // Busy flags and read data; rd_data moves only when a read completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_response_r <= 1'b0;
      rd_response_r <= 1'b0;
      rd_data_r     <= {DATA_W{1'b0}};
    end else begin
      if (wr_accept_s)    wr_response_r <= 1'b1;
      else if (wr_done_s) wr_response_r <= 1'b0;
      if (rd_accept_s)                         rd_response_r <= 1'b1;
      else if (rd_hit_done_s || rd_fill_done_s) rd_response_r <= 1'b0;
      if (rd_hit_done_s)       rd_data_r <= line_r[rd_idx_s];
      else if (rd_fill_done_s) rd_data_r <= ram_rdata_s;
    end
  end

  // Line valid bits: cleared by reset, set by a fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= {CACHE_LINES{1'b0}};
    end else if (rd_fill_done_s) begin
      valid_r[rd_idx_s] <= 1'b1;
    end
  end

  // Tag/data arrays: filled on a miss, refreshed when a write lands on a
  // resident line. Contents are qualified by valid_r, so no reset needed.
  always_ff @(posedge clk) begin
    if (rd_fill_done_s) begin
      tag_r[rd_idx_s]  <= rd_tag_s;
      line_r[rd_idx_s] <= ram_rdata_s;
    end else if (wr_done_s && wr_hit_s) begin
      line_r[wr_idx_s] <= wr_data_r;
    end
  end

  assign bus.wr_response = wr_response_r;
  assign bus.rd_response = rd_response_r;
  assign bus.rd_data     = rd_data_r;

endmodule

// File: tb/tb_cache_no_mode_top.sv
// tb_cache_no_mode_top
//   Directed bench for cache_no_mode_top. A word-array model of the RAM
//   supplies expected read data, pushed into a scoreboard queue when a read
//   is driven and popped when rd_response falls. Outputs sampled on negedge.
module tb_cache_no_mode_top;
  import cache_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  cache_no_mode_if bus ();

  cache_no_mode_top dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] mem_model [RAM_DEPTH];
  logic [31:0] sb_q [$];
  logic [31:0] last_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Drive a read, then measure busy cycles and compare the returned word.
  task automatic do_read(input string tag, input logic [31:0] addr, input int exp_busy,
                         input bit release_rst);
    int          busy;
    logic [31:0] exp_data;
    @(negedge clk);
    bus.rd_address = addr;
    if (release_rst) rst_n = 1'b1;
    sb_q.push_back(mem_model[addr[9:2]]);
    @(negedge clk);
    busy = 0;
    while (bus.rd_response === 1'b1 && busy < 50) begin
      busy++;
      @(negedge clk);
    end
    check({tag, " busy"}, 32'(busy), 32'(exp_busy));
    exp_data = sb_q.pop_front();
    check({tag, " data"}, bus.rd_data, exp_data);
    last_rd = exp_data;
  endtask

  // Drive a write and measure its busy window.
  task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data);
    int busy;
    @(negedge clk);
    bus.wr_address = addr;
    bus.wr_data    = data;
    bus.wr_mode    = 1'b1;
    mem_model[addr[9:2]] = data;
    @(negedge clk);
    busy = 0;
    while (bus.wr_response === 1'b1 && busy < 50) begin
      busy++;
      @(negedge clk);
    end
    bus.wr_mode = 1'b0;
    check({tag, " busy"}, 32'(busy), 32'd4);
  endtask

  initial begin
    int rd_busy;
    int wr_busy;
    for (int i = 0; i < RAM_DEPTH; i++) mem_model[i] = 32'h0;
    bus.wr_address = 32'h0;
    bus.wr_data    = 32'h0;
    bus.wr_mode    = 1'b0;
    bus.rd_address = 32'h0;
    last_rd        = 32'h0;

    // Reset state
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset wr_response", 32'(bus.wr_response), 32'd0);
    check("reset rd_response", 32'(bus.rd_response), 32'd0);
    check("reset rd_data", bus.rd_data, 32'h0);

    // First read after reset (address 0) misses and returns 0
    do_read("rd 0x0", 32'h0, 5, 1'b1);

    // Write then read-miss of the written word
    do_write("wr 0x10", 32'h10, 32'hDEADBEEF);
    do_read("rd 0x10 miss", 32'h10, 5, 1'b0);

    // Different line, then a hit
    do_read("rd 0x14 miss", 32'h14, 5, 1'b0);
    do_read("rd 0x10 hit", 32'h10, 1, 1'b0);

    // Eviction on the shared index
    do_read("rd 0x50 miss", 32'h50, 5, 1'b0);
    do_read("rd 0x10 evicted", 32'h10, 5, 1'b0);

    // Write-through refreshes the resident line; rd_data untouched by a write
    do_write("wr 0x10 again", 32'h10, 32'h12345678);
    check("rd_data held over write", bus.rd_data, last_rd);
    do_read("rd 0x14 hit", 32'h14, 1, 1'b0);
    do_read("rd 0x10 refreshed", 32'h10, 1, 1'b0);

    // Same-edge write and read of one word: read waits for the write
    @(negedge clk);
    bus.wr_address = 32'h20;
    bus.wr_data    = 32'hCAFEF00D;
    bus.wr_mode    = 1'b1;
    bus.rd_address = 32'h20;
    mem_model[8]   = 32'hCAFEF00D;
    sb_q.push_back(mem_model[8]);
    @(negedge clk);
    rd_busy = 0;
    wr_busy = 0;
    while ((bus.rd_response === 1'b1 || bus.wr_response === 1'b1) && rd_busy < 50) begin
      if (bus.rd_response === 1'b1) rd_busy++;
      if (bus.wr_response === 1'b1) wr_busy++;
      @(negedge clk);
    end
    bus.wr_mode = 1'b0;
    check("simul wr busy", 32'(wr_busy), 32'd4);
    check("simul rd outlasts wr", 32'(rd_busy > 4), 32'd1);
    last_rd = sb_q.pop_front();
    check("simul rd data", bus.rd_data, last_rd);

    // Reset in the middle of a miss
    @(negedge clk);
    bus.rd_address = 32'h30;
    @(negedge clk);
    @(negedge clk);
    check("mid-miss busy", 32'(bus.rd_response), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid-miss reset rd_response", 32'(bus.rd_response), 32'd0);
    check("mid-miss reset rd_data", bus.rd_data, 32'h0);
    check("mid-miss reset wr_response", 32'(bus.wr_response), 32'd0);
    repeat (2) @(negedge clk);
    do_read("rd 0x30 after reset", 32'h30, 5, 1'b1);
    do_read("rd 0x20 after reset", 32'h20, 5, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
